bru_resolve: RTL and testbench
==============================

Name: bru_resolve

Overview:
- EX-stage branch resolution unit. It is the consumer of the ID-stage static BTFN prediction.
- Recomputes the real outcome and target of B-type, JAL and JALR instructions and compares them against the prediction carried down id_ex.
- On a mismatch it issues a registered redirect to if/pc and holds a flush to the ctrl block for a fixed number of cycles.

Parameters:
- ADDR_W, 32, instruction address width
- DATA_W, 32, register data width
- FLUSH_CYCLES, 2, cycles flush_o stays high per mispredict (must be ≥1)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- ex_valid_i  in  1  id_ex holds a live instruction
- stall_i  in  1  pipeline stall from ctrl; EX does not advance
- ex_inst_i  in  32  instruction in EX
- ex_instaddr_i  in  ADDR_W  PC of that instruction
- ex_rs1_i  in  DATA_W  forwarded rs1 value
- ex_rs2_i  in  DATA_W  forwarded rs2 value
- ex_prd_jump_en_i  in  1  predicted taken, from ID
- ex_prd_target_i  in  ADDR_W  predicted target (base+offset), from ID
- redirect_en_o  out  1  one-cycle pulse: load redirect_addr_o into pc
- redirect_addr_o  out  ADDR_W  corrected fetch address
- flush_o  out  1  kill if_id and id_ex contents
- busy_o  out  1  FSM not IDLE
- br_cnt_o  out  32  resolved control-transfer count (see Optional Feature)
- mispred_cnt_o  out  32  mispredict count (see Optional Feature)

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; flush counter 0.
- Evaluation: an instruction is evaluated only when ex_valid_i=1, stall_i=0 and FSM=IDLE.
- Instruction classification uses opcode [6:0]:
  - B-type (1100011)
  - JAL (1101111)
  - JALR (1100111)
  - anything else: not a control transfer and never mispredicts.
- Actual outcome per class:
  - B: taken per funct3. 000 BEQ, 001 BNE, 100 BLT signed, 101 BGE signed, 110 BLTU, 111 BGEU. funct3 010/011 evaluate as not-taken. Target = PC + sext(imm_b).
  - JAL: always taken. Target = PC + sext(imm_j).
  - JALR: always taken. Target = (rs1 + sext(imm_i)) & ~1.
  - All address sums are modulo 2^ADDR_W; wrap-around is silently accepted.
- Mispredict conditions:
  - actual taken ≠ ex_prd_jump_en_i, or
  - both taken and actual target ≠ ex_prd_target_i.
- Correct address on mispredict: actual taken → actual target; actual not-taken → PC+4.
- FSM states: IDLE, REDIR, FLUSH.
  - IDLE→REDIR on a mispredict (registered, so 1-cycle latency).
  - In REDIR, for exactly one cycle: redirect_en_o=1, redirect_addr_o valid, flush_o=1.
  - REDIR→FLUSH if FLUSH_CYCLES>1, else REDIR→IDLE.
  - FLUSH holds flush_o=1 for FLUSH_CYCLES-1 cycles, counted by a down-counter, then →IDLE.
- While in REDIR or FLUSH, ex_valid_i is ignored: those are wrong-path instructions.
- redirect_addr_o holds its last value after the pulse; only redirect_en_o qualifies it.
- stall_i during REDIR/FLUSH does not freeze the FSM; the flush takes priority in ctrl.
- A back-to-back mispredict in the cycle after returning to IDLE is allowed (IDLE→REDIR).
- rst asserted in any state: outputs 0 immediately (asynchronous), FSM returns to IDLE.

Optional Feature:
- BRU_PERF_CNT_EN defined:
  - br_cnt_o increments on every evaluated B/JAL/JALR.
  - mispred_cnt_o increments on every mispredict.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- BRU_PERF_CNT_EN undefined: the ports remain but are tied to 0 and no counter flops exist.

Decomposition:
- Shared defines (existing core defines file):
  - opcodes INST_TYPE_B, INST_JAL, INST_JALR
  - funct3 codes INST_BEQ..INST_BGEU
  - JumpEnable/JumpDisable, ZeroWord
  - FSM encodings BRU_IDLE/BRU_REDIR/BRU_FLUSH
- Sub-module: bru_cmp, purely combinational. Inputs rs1, rs2, funct3; output taken. It is reused by any later EX branch logic.

Test Plan:
- BEQ at PC 0x100, imm +0x20, rs1=rs2=5, predicted not-taken (forward) → redirect_en_o pulse one cycle after EX, redirect_addr_o=0x120, flush_o high 2 cycles.
- BNE at PC 0x200, imm -0x10, rs1=rs2, predicted taken to 0x1F0 → redirect_addr_o=0x204; mispred_cnt_o=1 with BRU_PERF_CNT_EN.
- JALR at PC 0x300, rs1=0x1003, imm 4, predicted target 0x1007 → actual 0x1006 ≠ predicted → redirect to 0x1006. With predicted 0x1006 → no redirect, br_cnt_o increments.
- BLTU rs1=0xFFFFFFFF, rs2=1 → not-taken; BLT with same operands → taken. Predictions set opposite to each outcome → both redirect correctly.
- Mispredict followed by a valid mispredicting instruction during FLUSH → second ignored, exactly one redirect pulse; rst asserted mid-FLUSH → flush_o and busy_o drop at once.
- Stall: mispredicting branch with stall_i=1 for 3 cycles → no redirect until the first cycle with stall_i=0, then redirect pulses the next cycle.

Source files
------------

// File: rtl/bru_resolve_pkg.sv
// Shared opcode/funct3 encodings, FSM states and immediate decoders for the
// EX-stage branch resolution unit.
package bru_resolve_pkg;

  localparam logic [6:0] INST_TYPE_B = 7'b1100011;
  localparam logic [6:0] INST_JAL    = 7'b1101111;
  localparam logic [6:0] INST_JALR   = 7'b1100111;

  localparam logic [2:0] INST_BEQ  = 3'b000;
  localparam logic [2:0] INST_BNE  = 3'b001;
  localparam logic [2:0] INST_BLT  = 3'b100;
  localparam logic [2:0] INST_BGE  = 3'b101;
  localparam logic [2:0] INST_BLTU = 3'b110;
  localparam logic [2:0] INST_BGEU = 3'b111;

  localparam logic        JUMP_ENABLE  = 1'b1;
  localparam logic        JUMP_DISABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD    = 32'h0;

  typedef enum logic [1:0] {
    BRU_IDLE  = 2'd0,
    BRU_REDIR = 2'd1,
    BRU_FLUSH = 2'd2
  } bru_state_e;

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_i(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

endpackage

// File: rtl/bru_cmp.sv
// Combinational branch condition evaluator: funct3 selects the comparison.
module bru_cmp
  import bru_resolve_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] rs1,
  input  logic [DATA_W-1:0] rs2,
  input  logic [2:0]        funct3,
  output logic              taken
);

  always_comb begin
    taken = JUMP_DISABLE;
    case (funct3)
      INST_BEQ:  taken = (rs1 == rs2);
      INST_BNE:  taken = (rs1 != rs2);
      INST_BLT:  taken = ($signed(rs1) <  $signed(rs2));
      INST_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      INST_BLTU: taken = (rs1 <  rs2);
      INST_BGEU: taken = (rs1 >= rs2);
      default:   taken = JUMP_DISABLE;
    endcase
  end

endmodule

// File: rtl/bru_resolve.sv
// EX-stage branch resolution: checks the static prediction, issues a redirect
// and a multi-cycle flush on mispredict. Optional counters: BRU_PERF_CNT_EN.
module bru_resolve
  import bru_resolve_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  input  logic              stall_i,
  input  logic [31:0]       ex_inst_i,
  input  logic [ADDR_W-1:0] ex_instaddr_i,
  input  logic [DATA_W-1:0] ex_rs1_i,
  input  logic [DATA_W-1:0] ex_rs2_i,
  input  logic              ex_prd_jump_en_i,
  input  logic [ADDR_W-1:0] ex_prd_target_i,
  output logic              redirect_en_o,
  output logic [ADDR_W-1:0] redirect_addr_o,
  output logic              flush_o,
  output logic              busy_o,
  output logic [31:0]       br_cnt_o,
  output logic [31:0]       mispred_cnt_o
);

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  bru_state_e        state;
  logic [CNT_W-1:0]  flush_cnt;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              cmp_taken;
  logic              is_ctrl;
  logic              act_taken;
  logic [ADDR_W-1:0] act_target;
  logic [ADDR_W-1:0] pc_plus4;
  logic              eval;
  logic              mispredict;
  logic [ADDR_W-1:0] fix_addr;

  assign opcode   = ex_inst_i[6:0];
  assign funct3   = ex_inst_i[14:12];
  assign pc_plus4 = ex_instaddr_i + ADDR_W'(4);

  bru_cmp #(.DATA_W(DATA_W)) u_cmp (
    .rs1    (ex_rs1_i),
    .rs2    (ex_rs2_i),
    .funct3 (funct3),
    .taken  (cmp_taken)
  );

  // Actual outcome and target; all sums wrap modulo 2^ADDR_W.
  always_comb begin
    is_ctrl    = 1'b0;
    act_taken  = JUMP_DISABLE;
    act_target = '0;
    case (opcode)
      INST_TYPE_B: begin
        is_ctrl    = 1'b1;
        act_taken  = cmp_taken;
        act_target = ex_instaddr_i + ADDR_W'(signed'(imm_b(ex_inst_i)));
      end
      INST_JAL: begin
        is_ctrl    = 1'b1;
        act_taken  = JUMP_ENABLE;
        act_target = ex_instaddr_i + ADDR_W'(signed'(imm_j(ex_inst_i)));
      end
      INST_JALR: begin
        is_ctrl    = 1'b1;
        act_taken  = JUMP_ENABLE;
        act_target = (ADDR_W'(ex_rs1_i) + ADDR_W'(signed'(imm_i(ex_inst_i))))
                     & ~ADDR_W'(1);
      end
      default: begin
        is_ctrl    = 1'b0;
        act_taken  = JUMP_DISABLE;
        act_target = '0;
      end
    endcase
  end

  assign eval       = ex_valid_i && !stall_i && (state == BRU_IDLE);
  assign mispredict = is_ctrl && ((act_taken != ex_prd_jump_en_i) ||
                      (act_taken && (act_target != ex_prd_target_i)));
  assign fix_addr   = act_taken ? act_target : pc_plus4;

  // Redirect/flush sequencer; wrong-path instructions are ignored outside IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= BRU_IDLE;
      flush_cnt       <= '0;
      redirect_en_o   <= 1'b0;
      redirect_addr_o <= '0;
      flush_o         <= 1'b0;
      busy_o          <= 1'b0;
    end else begin
      case (state)
        BRU_IDLE: begin
          if (eval && mispredict) begin
            state           <= BRU_REDIR;
            redirect_en_o   <= JUMP_ENABLE;
            redirect_addr_o <= fix_addr;
            flush_o         <= 1'b1;
            busy_o          <= 1'b1;
          end
        end
        BRU_REDIR: begin
          redirect_en_o <= 1'b0;
          if (FLUSH_CYCLES > 1) begin
            state     <= BRU_FLUSH;
            flush_cnt <= CNT_W'(FLUSH_CYCLES - 1);
          end else begin
            state   <= BRU_IDLE;
            flush_o <= 1'b0;
            busy_o  <= 1'b0;
          end
        end
        BRU_FLUSH: begin
          if (flush_cnt <= CNT_W'(1)) begin
            state     <= BRU_IDLE;
            flush_cnt <= '0;
            flush_o   <= 1'b0;
            busy_o    <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - CNT_W'(1);
          end
        end
        default: begin
          state         <= BRU_IDLE;
          flush_cnt     <= '0;
          redirect_en_o <= 1'b0;
          flush_o       <= 1'b0;
          busy_o        <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRU_PERF_CNT_EN
  // Saturating resolved-transfer and mispredict counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_o      <= ZERO_WORD;
      mispred_cnt_o <= ZERO_WORD;
    end else if (eval && is_ctrl) begin
      if (br_cnt_o != 32'hFFFF_FFFF) begin
        br_cnt_o <= br_cnt_o + 32'd1;
      end
      if (mispredict && (mispred_cnt_o != 32'hFFFF_FFFF)) begin
        mispred_cnt_o <= mispred_cnt_o + 32'd1;
      end
    end
  end
`else
  assign br_cnt_o      = ZERO_WORD;
  assign mispred_cnt_o = ZERO_WORD;
`endif

endmodule

// File: tb/tb_bru_resolve.sv
// Directed bench for bru_resolve: expected redirect addresses are queued at
// issue time and matched against every redirect pulse the DUT emits.
module tb_bru_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i;
  logic        stall_i;
  logic [31:0] ex_inst_i;
  logic [31:0] ex_instaddr_i;
  logic [31:0] ex_rs1_i;
  logic [31:0] ex_rs2_i;
  logic        ex_prd_jump_en_i;
  logic [31:0] ex_prd_target_i;
  logic        redirect_en_o;
  logic [31:0] redirect_addr_o;
  logic        flush_o;
  logic        busy_o;
  logic [31:0] br_cnt_o;
  logic [31:0] mispred_cnt_o;

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp_br  = 32'd0;
  logic [31:0] exp_mis = 32'd0;

  bru_resolve #(.ADDR_W(32), .DATA_W(32), .FLUSH_CYCLES(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .ex_valid_i       (ex_valid_i),
    .stall_i          (stall_i),
    .ex_inst_i        (ex_inst_i),
    .ex_instaddr_i    (ex_instaddr_i),
    .ex_rs1_i         (ex_rs1_i),
    .ex_rs2_i         (ex_rs2_i),
    .ex_prd_jump_en_i (ex_prd_jump_en_i),
    .ex_prd_target_i  (ex_prd_target_i),
    .redirect_en_o    (redirect_en_o),
    .redirect_addr_o  (redirect_addr_o),
    .flush_o          (flush_o),
    .busy_o           (busy_o),
    .br_cnt_o         (br_cnt_o),
    .mispred_cnt_o    (mispred_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [11:0] imm);
    return {imm, 5'd1, 3'b000, 5'd1, 7'b1100111};
  endfunction

  // Every redirect pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && redirect_en_o) begin
      checks++;
      assert (sb_q.size() != 0) else begin
        failures++;
        $error("FAIL sb_extra observed redirect to %0h expected none", redirect_addr_o);
      end
      if (sb_q.size() != 0) chk("sb_addr", redirect_addr_o, sb_q.pop_front());
    end
  end

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic pen, input logic [31:0] ptgt);
    ex_valid_i       = 1'b1;
    ex_inst_i        = inst;
    ex_instaddr_i    = pc;
    ex_rs1_i         = rs1;
    ex_rs2_i         = rs2;
    ex_prd_jump_en_i = pen;
    ex_prd_target_i  = ptgt;
  endtask

  task automatic chk_cnt(input string tag);
`ifdef BRU_PERF_CNT_EN
    chk({tag, "_brcnt"}, br_cnt_o, exp_br);
    chk({tag, "_miscnt"}, mispred_cnt_o, exp_mis);
`else
    chk({tag, "_brcnt"}, br_cnt_o, 32'd0);
    chk({tag, "_miscnt"}, mispred_cnt_o, 32'd0);
`endif
  endtask

  // One evaluated instruction; on mispredict follows the full 2-cycle flush.
  task automatic issue(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic pen, input logic [31:0] ptgt,
                       input logic ctrl, input logic mis, input logic [31:0] addr);
    @(posedge clk); #1;
    drive(inst, pc, rs1, rs2, pen, ptgt);
    if (mis) sb_q.push_back(addr);
    if (ctrl) exp_br++;
    if (mis) exp_mis++;
    @(posedge clk); #1;
    ex_valid_i = 1'b0;
    chk({tag, "_redir"}, 32'(redirect_en_o), 32'(mis));
    chk({tag, "_flush"}, 32'(flush_o), 32'(mis));
    if (mis) begin
      chk({tag, "_addr"}, redirect_addr_o, addr);
      @(posedge clk); #1;
      chk({tag, "_redir2"}, 32'(redirect_en_o), 32'd0);
      chk({tag, "_flush2"}, 32'(flush_o), 32'd1);
      @(posedge clk); #1;
      chk({tag, "_flush3"}, 32'(flush_o), 32'd0);
      chk({tag, "_busy3"}, 32'(busy_o), 32'd0);
    end
    chk_cnt(tag);
  endtask

  initial begin
    rst = 1'b1;
    stall_i = 1'b0;
    drive(32'h0000_0013, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    ex_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_redir", 32'(redirect_en_o), 32'd0);
    chk("rst_addr", redirect_addr_o, 32'd0);
    chk("rst_flush", 32'(flush_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk_cnt("rst");
    rst = 1'b0;

    issue("beq", enc_b(3'b000, 13'h020), 32'h100, 32'd5, 32'd5, 1'b0, 32'h0,
          1'b1, 1'b1, 32'h120);
    issue("bne", enc_b(3'b001, 13'h1FF0), 32'h200, 32'd7, 32'd7, 1'b1, 32'h1F0,
          1'b1, 1'b1, 32'h204);
    issue("jalr_bad", enc_jalr(12'd4), 32'h300, 32'h1003, 32'h0, 1'b1, 32'h1007,
          1'b1, 1'b1, 32'h1006);
    issue("jalr_ok", enc_jalr(12'd4), 32'h300, 32'h1003, 32'h0, 1'b1, 32'h1006,
          1'b1, 1'b0, 32'h0);
    issue("bltu", enc_b(3'b110, 13'h040), 32'h400, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h440,
          1'b1, 1'b1, 32'h404);
    issue("blt", enc_b(3'b100, 13'h040), 32'h400, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0,
          1'b1, 1'b1, 32'h440);
    issue("beq_ok", enc_b(3'b000, 13'h1FF8), 32'h480, 32'd3, 32'd3, 1'b1, 32'h478,
          1'b1, 1'b0, 32'h0);
    issue("addi", 32'h0010_0093, 32'h490, 32'd0, 32'd0, 1'b1, 32'h123,
          1'b0, 1'b0, 32'h0);
    issue("f3_010", enc_b(3'b010, 13'h020), 32'h4A0, 32'd9, 32'd9, 1'b1, 32'h4C0,
          1'b1, 1'b1, 32'h4A4);
    issue("jal_ok", enc_j(21'h100), 32'h500, 32'h0, 32'h0, 1'b1, 32'h600,
          1'b1, 1'b0, 32'h0);
    issue("jal_bad", enc_j(21'h100), 32'h500, 32'h0, 32'h0, 1'b1, 32'h700,
          1'b1, 1'b1, 32'h600);
    issue("jal_wrap", enc_j(21'h020), 32'hFFFF_FFF0, 32'h0, 32'h0, 1'b0, 32'h0,
          1'b1, 1'b1, 32'h10);

    // Stalled mispredict: nothing happens until stall drops.
    @(posedge clk); #1;
    stall_i = 1'b1;
    drive(enc_b(3'b000, 13'h020), 32'h100, 32'd1, 32'd1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_redir", 32'(redirect_en_o), 32'd0);
      chk("stall_busy", 32'(busy_o), 32'd0);
    end
    stall_i = 1'b0;
    sb_q.push_back(32'h120);
    exp_br++;
    exp_mis++;
    @(posedge clk); #1;
    ex_valid_i = 1'b0;
    chk("stall_rel_redir", 32'(redirect_en_o), 32'd1);
    chk("stall_rel_addr", redirect_addr_o, 32'h120);
    repeat (2) @(posedge clk);
    #1;
    chk("stall_done_busy", 32'(busy_o), 32'd0);
    chk_cnt("stall");

    // Wrong-path mispredicts during REDIR/FLUSH are ignored; back-to-back after IDLE.
    @(posedge clk); #1;
    drive(enc_b(3'b001, 13'h010), 32'h600, 32'd1, 32'd2, 1'b0, 32'h0);
    sb_q.push_back(32'h610);
    exp_br++;
    exp_mis++;
    @(posedge clk); #1;
    chk("wp_redir", 32'(redirect_en_o), 32'd1);
    drive(enc_j(21'h040), 32'h700, 32'h0, 32'h0, 1'b0, 32'h0);
    @(posedge clk); #1;
    chk("wp_flush_state", 32'(flush_o), 32'd1);
    chk("wp_no_redir", 32'(redirect_en_o), 32'd0);
    @(posedge clk); #1;
    chk("wp_idle_busy", 32'(busy_o), 32'd0);
    drive(enc_j(21'h080), 32'h800, 32'h0, 32'h0, 1'b0, 32'h0);
    sb_q.push_back(32'h880);
    exp_br++;
    exp_mis++;
    @(posedge clk); #1;
    ex_valid_i = 1'b0;
    chk("b2b_redir", 32'(redirect_en_o), 32'd1);
    chk("b2b_addr", redirect_addr_o, 32'h880);
    @(posedge clk); #1;
    chk("b2b_flush", 32'(flush_o), 32'd1);

    // Reset in the middle of FLUSH drops everything immediately.
    #2;
    rst = 1'b1;
    #1;
    chk("rstf_flush", 32'(flush_o), 32'd0);
    chk("rstf_busy", 32'(busy_o), 32'd0);
    chk("rstf_redir", 32'(redirect_en_o), 32'd0);
    exp_br  = 32'd0;
    exp_mis = 32'd0;
    chk_cnt("rstf");
    @(posedge clk); #1;
    rst = 1'b0;
    issue("post_rst", enc_b(3'b101, 13'h1FE0), 32'h900, 32'hFFFF_FFFE, 32'd1, 1'b1, 32'h8E0,
          1'b1, 1'b1, 32'h904);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
